mux_rr_n: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with a round-robin arbiter and valid/ready handshakes on every input and on the output. It generalises the processor's fixed 2:1 32-bit select mux. Several datapath sources share one sink, such as write-back sources or memory requesters in Antares-R2, and no source may be starved or lose data under backpressure.

---
 rtl/mux_rr_n.sv | 130 +++++++++++++
 tb/tb_mux_rr_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel registered multiplexer with round-robin grant and valid/ready on every port.
// Optional burst lock (hold the grant until in_last) is enabled by defining MUX_RR_LOCK_EN.
module mux_rr_n #(
  parameter  int N     = 4,
  parameter  int WIDTH = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_last_i,
  output logic [N-1:0]       in_ready_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_sel_o,
  input  logic               out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] last_q,      last_d;

  logic             accept;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;
  int               cand;

`ifdef MUX_RR_LOCK_EN
  logic             lock_q,    lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
`else
  // in_last only matters for burst lock; fold it into a deliberately unused net.
  logic             unused_in_last;
  assign unused_in_last = ^in_last_i;
`endif

  assign accept = !out_valid_q || out_ready_i;

  // Scan last+1, last+2, ... modulo N; the first valid channel wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_q) + k) % N;
      if (!gnt_found && in_valid_i[SEL_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL_W'(cand);
      end
    end
`ifdef MUX_RR_LOCK_EN
    // A locked burst owns the grant even while its source is momentarily idle.
    if (lock_q) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_ch_q;
    end
`endif
  end

  assign gnt_data = in_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
  assign xfer     = gnt_found && accept && in_valid_i[gnt_idx];

  always_comb begin
    in_ready_o = '0;
    if (gnt_found && accept && rst_n_i) in_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      last_d      = gnt_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_RR_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (lock_q) begin
        if (in_last_i[gnt_idx]) lock_d = 1'b0;
      end else if (!in_last_i[gnt_idx]) begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: directed scenarios plus randomized traffic against a grant-order model and scoreboard.
module tb_mux_rr_n;
  localparam int N = 4;
  localparam int W = 32;
`ifdef MUX_RR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid = '0, in_last = '0, in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid, out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  logic [2:0]     v3 = '0, l3 = '0, r3;
  logic [3*W-1:0] d3 = '0;
  logic           ov3, or3 = 1'b1;
  logic [W-1:0]   od3;
  logic [1:0]     os3;

  always #5 clk = ~clk;

  mux_rr_n #(.N(N), .WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_sel_o(out_sel), .out_ready_i(out_ready));

  mux_rr_n #(.N(3), .WIDTH(W)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(v3), .in_data_i(d3),
    .in_last_i(l3), .in_ready_o(r3), .out_valid_o(ov3),
    .out_data_o(od3), .out_sel_o(os3), .out_ready_i(or3));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] chan_data [N];

  // Reference model: output holding register, pointer to last grant, burst lock.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel, m_last, m_lch;
  bit           m_lock;
  int           exp_g;
  logic [N-1:0] exp_ready;
  bit           exp_xfer;
  logic [W+1:0] sb [$];

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_last = N - 1; m_lock = 0; m_lch = 0;
    sb.delete();
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input bit ordy);
    bit acc;
    in_valid = v; in_last = l; out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chan_data[i];
    exp_g = -1;
    if (m_lock) exp_g = m_lch;
    else for (int k = 1; k <= N; k++)
      if (exp_g < 0 && v[(m_last + k) % N]) exp_g = (m_last + k) % N;
    acc       = !m_valid || ordy;
    exp_ready = (exp_g >= 0 && acc) ? (N'(1) << exp_g) : '0;
    exp_xfer  = (exp_g >= 0) && acc && v[exp_g];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_xfer) begin
      m_valid = 1; m_data = chan_data[exp_g]; m_sel = exp_g; m_last = exp_g;
      if (LOCK_EN) begin
        if (m_lock) begin
          if (in_last[exp_g]) m_lock = 0;
        end else if (!in_last[exp_g]) begin
          m_lock = 1; m_lch = exp_g;
        end
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = '0; in_last = '0; out_ready = 0; v3 = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = '1; out_ready = 1;
    for (int i = 0; i < N; i++) begin
      chan_data[i] = W'(32'hA0 + i);
      in_data[i*W +: W] = chan_data[i];
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    apply('1, '0, 1);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0)
      begin errors++; $display("FAIL reset_first_beat got v=%0b sel=%0d data=%h want v=1 sel=0 data=a0", out_valid, out_sel, out_data); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = W'(32'hA0 + i);
    for (int c = 0; c < 8; c++) begin
      apply('1, '0, 1);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rotation_ready[%0d] got %b want %b", c, in_ready, exp_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== W'(32'hA0 + c % 4))
        begin errors++; $display("FAIL rotation_beat[%0d] got sel=%0d data=%h want sel=%0d data=%h", c, out_sel, out_data, c % 4, 32'hA0 + c % 4); end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      apply('1, '0, 0);
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 32'hA3)
        begin errors++; $display("FAIL stall_hold[%0d] got v=%0b sel=%0d data=%h want v=1 sel=3 data=a3", c, out_valid, out_sel, out_data); end
    end
    apply('1, '0, 1);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b want 0001", in_ready); end
    tick();
    checks++; if (out_sel !== 2'd0 || out_data !== 32'hA0)
      begin errors++; $display("FAIL stall_release_beat got sel=%0d data=%h want sel=0 data=a0", out_sel, out_data); end
  endtask

  task automatic test_sparse_wrap();
    int seq4 [4] = '{1, 3, 1, 3};
    int seq3 [4] = '{0, 1, 2, 0};
    do_reset();
    v3 = 3'b111;
    for (int i = 0; i < 3; i++) d3[i*W +: W] = W'(32'hC0 + i);
    for (int c = 0; c < 4; c++) begin
      apply(4'b1010, '0, 1);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL sparse_ready[%0d] got %b want %b", c, in_ready, exp_ready); end
      tick();
      checks++; if (out_sel !== 2'(seq4[c])) begin errors++; $display("FAIL sparse_sel[%0d] got %0d want %0d", c, out_sel, seq4[c]); end
      checks++; if (ov3 !== 1'b1 || os3 !== 2'(seq3[c]) || od3 !== W'(32'hC0 + seq3[c]))
        begin errors++; $display("FAIL wrap3_sel[%0d] got v=%0b sel=%0d data=%h want sel=%0d", c, ov3, os3, od3, seq3[c]); end
    end
    v3 = '0;
  endtask

  task automatic test_async_reset();
    apply('1, '0, 1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b want 1", out_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== '0 || out_sel !== 2'd0)
      begin errors++; $display("FAIL areset_immediate got v=%0b rdy=%b sel=%0d want v=0 rdy=0000 sel=0", out_valid, in_ready, out_sel); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    apply('1, '0, 1);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL areset_pointer got %b want 0001", in_ready); end
    tick();
  endtask

  task automatic test_lock();
    int want [4];
    int s1 = 0, s2 = 0;
    logic [N-1:0] v, l;
    bit a1, a2;
    if (LOCK_EN) want = '{1, 1, 1, 2}; else want = '{1, 2, 1, 2};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      chan_data[1] = W'(32'h100 + s1);
      chan_data[2] = W'(32'h200 + s2);
      v = '0; l = '0;
      v[2] = 1'b1;
      v[1] = (s1 < 3);
      l[1] = (s1 == 2);
      apply(v, l, 1);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL lock_ready[%0d] got %b want %b", c, in_ready, exp_ready); end
      a1 = in_valid[1] && in_ready[1];
      a2 = in_valid[2] && in_ready[2];
      tick();
      checks++; if (out_sel !== 2'(want[c])) begin errors++; $display("FAIL lock_sel[%0d] got %0d want %0d", c, out_sel, want[c]); end
      if (a1) s1++;
      if (a2) s2++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend = '0, lastv = '0, acc;
    bit ordy;
    logic [W+1:0] front;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          chan_data[i] = $urandom;
          lastv[i] = 1'($urandom_range(0, 1));
        end
      ordy = ($urandom_range(0, 3) != 0);
      apply(pend, lastv, ordy);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, in_ready, exp_ready); end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rand_sb_extra[%0d] got sel=%0d data=%h want no beat", c, out_sel, out_data); end
        else begin
          front = sb.pop_front();
          if ({out_sel, out_data} !== front)
            begin errors++; $display("FAIL rand_sb[%0d] got sel=%0d data=%h want sel=%0d data=%h", c, out_sel, out_data, front[W+1:W], front[W-1:0]); end
        end
      end
      acc = in_valid & in_ready;
      for (int i = 0; i < N; i++)
        if (acc[i]) sb.push_back({2'(i), chan_data[i]});
      tick();
      pend = pend & ~acc;
      checks++; if (out_valid !== m_valid || (m_valid && (out_sel !== 2'(m_sel) || out_data !== m_data)))
        begin errors++; $display("FAIL rand_out[%0d] got v=%0b sel=%0d data=%h want v=%0b sel=%0d data=%h", c, out_valid, out_sel, out_data, m_valid, m_sel, m_data); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_async_reset();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
